// File: rtl/i2s_adc_rx.sv
// I2S receive deserializer for the WM8731 ADC path.
//
// Oversamples the externally generated bclk/lrclk and the codec's adcdat in the clk
// domain. It deserializes MSB-first stereo words and presents each completed left/right
// pair on a valid/ready port.
//
// Ports:
//   clk, rst          system clock (256*fs) and asynchronous active-low reset
//   en                synchronous enable; low forces resync and drops the partial word
//   i2s_bclk          bit clock from the timing generator
//   i2s_lrclk         word clock (0 = left, 1 = right)
//   i2s_adcdat        serial data, launched on the falling edge of bclk
//   out_left/right    most recent sample pair
//   out_valid         pair available, held until accepted with out_ready
//   out_ready         consumer accepts the pair
//   short_word        sticky: a channel ended with fewer than DATA_WIDTH bits
//   overrun           sticky: an unaccepted pair was overwritten
//   clr_status        synchronous clear of the sticky flags (a set in the same cycle wins)
module i2s_adc_rx #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_adcdat,
  output logic [DATA_WIDTH-1:0] out_left,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  short_word,
  output logic                  overrun,
  input  logic                  clr_status
);

  typedef enum logic [1:0] {StWaitSync, StDelay, StShift, StHold} state_e;

  localparam logic [CNT_WIDTH-1:0] FullCnt = CNT_WIDTH'(DATA_WIDTH);

  // Only bclk needs the second stage, for rising-edge detection.
  logic bclk_s1, bclk_s2, lrclk_s1, adcdat_s1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  lr_prev_q, lr_prev_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic [DATA_WIDTH-1:0] out_left_q, out_left_d;
  logic [DATA_WIDTH-1:0] out_right_q, out_right_d;
  logic                  out_valid_q, out_valid_d;
  logic                  short_q, short_d;
  logic                  overrun_q, overrun_d;

  logic                  bclk_event;
  logic                  lr_change;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic [CNT_WIDTH-1:0]  shift_amt;
  logic [DATA_WIDTH-1:0] word;
  logic                  finalize;
  logic                  pair_wr;

  assign bclk_event = bclk_s1 & ~bclk_s2;
  assign lr_change  = bclk_event & (lrclk_s1 != lr_prev_q);
  assign cnt_inc    = bit_cnt_q + 1'b1;
  // Left-align a partial word; missing LSBs come out as zero.
  assign shift_amt  = FullCnt - bit_cnt_q;
  assign word       = shreg_q << shift_amt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bclk_s1   <= 1'b0;
      bclk_s2   <= 1'b0;
      lrclk_s1  <= 1'b0;
      adcdat_s1 <= 1'b0;
    end else begin
      bclk_s1   <= i2s_bclk;
      bclk_s2   <= bclk_s1;
      lrclk_s1  <= i2s_lrclk;
      adcdat_s1 <= i2s_adcdat;
    end
  end

  // The event on which the lrclk change is seen carries the one-bit I2S delay slot and is
  // discarded; the first event spent in StDelay is the MSB. A slot of N bclk thus yields
  // min(N-1, DATA_WIDTH) data bits.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    lr_prev_d   = bclk_event ? lrclk_s1 : lr_prev_q;
    left_hold_d = left_hold_q;
    finalize    = 1'b0;
    pair_wr     = 1'b0;

    if (!en) begin
      state_d   = StWaitSync;
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (bclk_event) begin
      if (state_q == StWaitSync) begin
        shreg_d   = '0;
        bit_cnt_d = '0;
        if (lr_change && !lrclk_s1) begin
          state_d = StDelay;
        end
      end else if (lr_change) begin
        // Channel boundary: lrclk direction tells which word just ended.
        finalize  = 1'b1;
        state_d   = StDelay;
        shreg_d   = '0;
        bit_cnt_d = '0;
        if (lrclk_s1) begin
          left_hold_d = word;
        end else begin
          pair_wr = 1'b1;
        end
      end else begin
        case (state_q)
          StDelay, StShift: begin
            shreg_d   = {shreg_q[DATA_WIDTH-2:0], adcdat_s1};
            bit_cnt_d = cnt_inc;
            state_d   = (cnt_inc == FullCnt) ? StHold : StShift;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    out_left_d  = pair_wr ? left_hold_q : out_left_q;
    out_right_d = pair_wr ? word : out_right_q;
    if (pair_wr) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    short_d   = (short_q & ~clr_status) | (finalize & (bit_cnt_q < FullCnt));
    overrun_d = (overrun_q & ~clr_status) | (pair_wr & out_valid_q & ~out_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StWaitSync;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      lr_prev_q   <= 1'b1;
      left_hold_q <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      short_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      lr_prev_q   <= lr_prev_d;
      left_hold_q <= left_hold_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      short_q     <= short_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_left   = out_left_q;
  assign out_right  = out_right_q;
  assign out_valid  = out_valid_q;
  assign short_word = short_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed testbench for i2s_adc_rx: drives an I2S stream (3 clk per bclk phase) and
// checks outputs against hand-computed values.
module tb_i2s_adc_rx;

  localparam int unsigned DW = 24;

  logic          clk;
  logic          rst;
  logic          en;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_adcdat;
  logic [DW-1:0] out_left;
  logic [DW-1:0] out_right;
  logic          out_valid;
  logic          out_ready;
  logic          short_word;
  logic          overrun;
  logic          clr_status;

  int   n_checks;
  int   n_errors;
  // out_valid sampled after the 1st and 2nd clk edges following each bclk rise.
  logic lat_v1;
  logic lat_v2;

  i2s_adc_rx #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_adcdat(i2s_adcdat),
    .out_left  (out_left),
    .out_right (out_right),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .short_word(short_word),
    .overrun   (overrun),
    .clr_status(clr_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bclk period; entered and left on a clk falling edge. lrclk/data change with bclk low.
  task automatic bclk_bit(input logic lr, input logic d);
    i2s_bclk   = 1'b0;
    i2s_lrclk  = lr;
    i2s_adcdat = d;
    repeat (3) @(negedge clk);
    i2s_bclk = 1'b1;
    @(posedge clk);
    #1 lat_v1 = out_valid;
    @(posedge clk);
    #1 lat_v2 = out_valid;
    repeat (2) @(negedge clk);
  endtask

  // MSB-first data bits; bits past DW are sent as 1 so they must be ignored.
  task automatic send_bits(input logic lr, input logic [DW-1:0] word, input int nbits);
    logic [DW-1:0] tmp;
    tmp = word;
    for (int i = 0; i < nbits; i++) begin
      if (i < DW) begin
        bclk_bit(lr, tmp[DW-1]);
        tmp = tmp << 1;
      end else begin
        bclk_bit(lr, 1'b1);
      end
    end
  endtask

  // Starts just after a left delay bit; ends with the next left delay bit (pair emission).
  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int n);
    send_bits(1'b0, l, n - 1);
    bclk_bit(1'b1, 1'b1);
    send_bits(1'b1, r, n - 1);
    bclk_bit(1'b0, 1'b1);
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    lat_v1     = 1'b0;
    lat_v2     = 1'b0;
    rst        = 1'b0;
    en         = 1'b0;
    i2s_bclk   = 1'b0;
    i2s_lrclk  = 1'b1;
    i2s_adcdat = 1'b0;
    out_ready  = 1'b0;
    clr_status = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_left", out_left, 0);
    check("rst_right", out_right, 0);
    check("rst_valid", out_valid, 0);
    check("rst_short", short_word, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);

    // Stream starts mid right word: nothing until sync plus a full frame.
    send_bits(1'b1, 24'h123456, 12);
    check("align_valid", out_valid, 0);
    bclk_bit(1'b0, 1'b1);
    check("sync_no_emit", lat_v2, 0);

    // Basic frame, 32 bclk per channel.
    send_frame(24'hA5C3F0, 24'h0F1E2D, 32);
    check("basic_lat1", lat_v1, 0);
    check("basic_lat2", lat_v2, 1);
    check("basic_left", out_left, 24'hA5C3F0);
    check("basic_right", out_right, 24'h0F1E2D);
    check("basic_short", short_word, 0);
    check("basic_overrun", overrun, 0);

    // Accept.
    pulse_ready();
    check("accept_valid", out_valid, 0);

    // Backpressure across two frames.
    send_frame(24'h111111, 24'h000001, 32);
    check("bp1_valid", out_valid, 1);
    check("bp1_right", out_right, 24'h000001);
    check("bp1_overrun", overrun, 0);
    send_frame(24'h222222, 24'h000002, 32);
    check("bp2_lat1", lat_v1, 1);
    check("bp2_valid", out_valid, 1);
    check("bp2_left", out_left, 24'h222222);
    check("bp2_right", out_right, 24'h000002);
    check("bp2_overrun", overrun, 1);
    pulse_clr();
    check("clr_overrun", overrun, 0);
    pulse_ready();
    check("bp_accept", out_valid, 0);

    // Short slot: 24 bclk gives 23 data bits.
    send_frame(24'hFFFFFF, 24'hABCDEF, 24);
    check("short_left", out_left, 24'hFFFFFE);
    check("short_right", out_right, 24'hABCDEE);
    check("short_flag", short_word, 1);
    check("short_overrun", overrun, 0);
    pulse_clr();
    check("short_clr", short_word, 0);

    // Reset in the middle of the left word, released during the right word.
    send_bits(1'b0, 24'h333333, 10);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_left", out_left, 0);
    check("mrst_right", out_right, 0);
    check("mrst_valid", out_valid, 0);
    send_bits(1'b0, 24'h333333, 21);
    bclk_bit(1'b1, 1'b1);
    send_bits(1'b1, 24'h777777, 5);
    rst = 1'b1;
    send_bits(1'b1, 24'h777777, 26);
    bclk_bit(1'b0, 1'b1);
    check("mrst_sync", lat_v2, 0);
    send_frame(24'h456789, 24'h9ABCDE, 32);
    check("mrst_lat1", lat_v1, 0);
    check("mrst_lat2", lat_v2, 1);
    check("mrst_fleft", out_left, 24'h456789);
    check("mrst_fright", out_right, 24'h9ABCDE);
    check("mrst_short", short_word, 0);

    // Enable dropped mid left word, restored during the right word; pair left unaccepted.
    send_bits(1'b0, 24'h555555, 8);
    en = 1'b0;
    @(negedge clk);
    check("en_keep_left", out_left, 24'h456789);
    check("en_keep_valid", out_valid, 1);
    send_bits(1'b0, 24'h555555, 23);
    bclk_bit(1'b1, 1'b1);
    send_bits(1'b1, 24'h666666, 10);
    en = 1'b1;
    send_bits(1'b1, 24'h666666, 21);
    bclk_bit(1'b0, 1'b1);
    check("en_resync_left", out_left, 24'h456789);
    check("en_resync_right", out_right, 24'h9ABCDE);
    check("en_no_overrun", overrun, 0);
    send_frame(24'h0BADF0, 24'h00C0DE, 32);
    check("en_left", out_left, 24'h0BADF0);
    check("en_right", out_right, 24'h00C0DE);
    check("en_overrun", overrun, 1);
    check("en_valid", out_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
